// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter
// Lets two requesters share the register file's single write/read-B port.
// Requester 0 is the processor core. Requester 1 is the key-load/debug engine.
// Arbitration is round-robin. A requester may lock the port for a short burst.
// Reads return data one cycle after acceptance.
module regfile_port_arbiter #(
    parameter int AW         = 2,
    parameter int DW         = 8,
    parameter int PRIO_RESET = 0,
    parameter int MAX_LOCK   = 4
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [1:0]           ReqValid,
    output logic [1:0]           ReqReady,
    input  logic [1:0]           ReqWe,
    input  logic [1:0][AW-1:0]   ReqAddr,
    input  logic [1:0][DW-1:0]   ReqWdata,
    input  logic [1:0]           ReqLock,
    output logic [1:0]           RspValid,
    output logic [1:0][DW-1:0]   RspRdata,
    output logic                 RfWriteEn,
    output logic [AW-1:0]        RfAddrB,
    output logic [DW-1:0]        RfDataIn,
    input  logic [DW-1:0]        RfDataOutB
);

    // Lock counter only needs to reach MAX_LOCK-1, where release is forced.
    localparam int LCW = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;
    localparam logic [LCW-1:0] LOCK_LAST = LCW'(MAX_LOCK - 1);
    localparam logic [LCW-1:0] LOCK_ONE  = LCW'(1);

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        HOLD0 = 2'd1,
        HOLD1 = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic             rr_ptr_reg;
    logic             rr_ptr_next;
    logic [LCW-1:0]   lock_cnt_reg;
    logic [LCW-1:0]   lock_cnt_next;

    // Grant vector. A grant implies the requester is valid, so grant[n] marks a transfer.
    logic [1:0]       grant;
    logic             gnt_any;
    logic             gnt_idx;
    logic             hold_idx;
    logic             release_hold;

    // Per-requester response registers.
    logic             rsp_valid_reg [2];
    logic [DW-1:0]    rsp_rdata_reg [2];

    // Arbitration state. Any burst in progress is abandoned when Reset is asserted.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg    <= ARB;
            rr_ptr_reg   <= 1'(PRIO_RESET);
            lock_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            rr_ptr_reg   <= rr_ptr_next;
            lock_cnt_reg <= lock_cnt_next;
        end
    end

    // Grant selection. While Reset is high, nothing is granted.
    always_comb begin
        grant    = '0;
        hold_idx = 1'b0;
        case (state_reg)
            ARB: begin
                if (ReqValid[0] && (!ReqValid[1] || !rr_ptr_reg)) begin
                    grant[0] = 1'b1;
                end else if (ReqValid[1]) begin
                    grant[1] = 1'b1;
                end
            end
            HOLD0: begin
                hold_idx = 1'b0;
                grant[0] = ReqValid[0];
            end
            HOLD1: begin
                hold_idx = 1'b1;
                grant[1] = ReqValid[1];
            end
            default: grant = '0;
        endcase
        if (Reset) begin
            grant = '0;
        end
        gnt_any = |grant;
        gnt_idx = grant[1];
    end

    // Next-state logic: round-robin pointer update, lock entry, and lock release.
    always_comb begin
        state_next    = state_reg;
        rr_ptr_next   = rr_ptr_reg;
        lock_cnt_next = lock_cnt_reg;
        release_hold  = 1'b0;
        case (state_reg)
            ARB: begin
                if (gnt_any) begin
                    rr_ptr_next = ~gnt_idx;
                    if (ReqLock[gnt_idx]) begin
                        state_next    = gnt_idx ? HOLD1 : HOLD0;
                        lock_cnt_next = '0;
                    end
                end
            end
            HOLD0, HOLD1: begin
                // The counter runs whether or not the owner transfers. Dropping
                // valid therefore cannot stretch the lock past MAX_LOCK cycles.
                lock_cnt_next = lock_cnt_reg + LOCK_ONE;
                release_hold  = (gnt_any && !ReqLock[hold_idx]) ||
                                (lock_cnt_reg == LOCK_LAST);
                if (release_hold) begin
                    state_next    = ARB;
                    rr_ptr_next   = ~hold_idx;
                    lock_cnt_next = '0;
                end
            end
            default: begin
                state_next    = ARB;
                lock_cnt_next = '0;
            end
        endcase
    end

    // Drive the register file port from the granted requester, or park it at zero.
    always_comb begin
        RfWriteEn = 1'b0;
        RfAddrB   = '0;
        RfDataIn  = '0;
        if (gnt_any) begin
            RfWriteEn = ReqWe[gnt_idx];
            RfAddrB   = ReqAddr[gnt_idx];
            RfDataIn  = ReqWdata[gnt_idx];
        end
    end

    assign ReqReady = grant;

    // One response path per requester.
    // Accepted reads capture B-port data one cycle later.
    // The data holds until the next read by the same requester.
    for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
        logic rd_accept;
        assign rd_accept = grant[gi] & ~ReqWe[gi];

        // Response pulse and captured read data.
        // A read still pending when Reset arrives is discarded.
        always_ff @(posedge Clk or posedge Reset) begin
            if (Reset) begin
                rsp_valid_reg[gi] <= 1'b0;
                rsp_rdata_reg[gi] <= '0;
            end else begin
                rsp_valid_reg[gi] <= rd_accept;
                if (rd_accept) begin
                    rsp_rdata_reg[gi] <= RfDataOutB;
                end
            end
        end

        assign RspValid[gi] = rsp_valid_reg[gi];
        assign RspRdata[gi] = rsp_rdata_reg[gi];
    end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// tb_regfile_port_arbiter
// Directed bench for regfile_port_arbiter.
// A small behavioural register file sits on port B.
// Inputs change on the falling edge.
// Combinational outputs are sampled 1 ns later.
// Registered outputs are sampled 1 ns after the rising edge.
module tb_regfile_port_arbiter;

    logic             Clk;
    logic             Reset;
    logic [1:0]       ReqValid;
    logic [1:0]       ReqReady;
    logic [1:0]       ReqWe;
    logic [1:0][1:0]  ReqAddr;
    logic [1:0][7:0]  ReqWdata;
    logic [1:0]       ReqLock;
    logic [1:0]       RspValid;
    logic [1:0][7:0]  RspRdata;
    logic             RfWriteEn;
    logic [1:0]       RfAddrB;
    logic [7:0]       RfDataIn;
    logic [7:0]       RfDataOutB;

    int errors = 0;
    int checks = 0;

    logic [7:0] rf [4];

    regfile_port_arbiter #(
        .AW(2), .DW(8), .PRIO_RESET(0), .MAX_LOCK(4)
    ) dut (
        .Clk(Clk), .Reset(Reset),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWe(ReqWe),
        .ReqAddr(ReqAddr), .ReqWdata(ReqWdata), .ReqLock(ReqLock),
        .RspValid(RspValid), .RspRdata(RspRdata),
        .RfWriteEn(RfWriteEn), .RfAddrB(RfAddrB), .RfDataIn(RfDataIn),
        .RfDataOutB(RfDataOutB)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Register file model: synchronous write, combinational read on B.
    always @(posedge Clk) if (RfWriteEn) rf[RfAddrB] <= RfDataIn;
    assign RfDataOutB = rf[RfAddrB];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int n, input logic v, input logic we,
                           input logic [1:0] a, input logic [7:0] d, input logic lk);
        ReqValid[n] = v;
        ReqWe[n]    = we;
        ReqAddr[n]  = a;
        ReqWdata[n] = d;
        ReqLock[n]  = lk;
    endtask

    task automatic idle_all();
        set_req(0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
        set_req(1, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++) rf[i] = 8'h00;

        // ---------------- reset behaviour ----------------
        Reset = 1'b1;
        set_req(0, 1'b1, 1'b1, 2'd3, 8'hFF, 1'b1);
        set_req(1, 1'b1, 1'b1, 2'd1, 8'hEE, 1'b1);
        #1;
        check("rst_ready",  ReqReady, 2'b00);
        check("rst_we",     RfWriteEn, 1'b0);
        check("rst_addr",   RfAddrB, 2'd0);
        check("rst_din",    RfDataIn, 8'h00);
        tick();
        check("rst_rspv",   RspValid, 2'b00);
        check("rst_rdata1", RspRdata[1], 8'h00);
        @(negedge Clk);
        Reset = 1'b0;

        // ---------------- test 1: write then read back ----------------
        idle_all();
        set_req(0, 1'b1, 1'b1, 2'd2, 8'hA5, 1'b0);
        #1;
        check("t1_wr_ready", ReqReady, 2'b01);
        check("t1_wr_we",    RfWriteEn, 1'b1);
        check("t1_wr_addr",  RfAddrB, 2'd2);
        check("t1_wr_din",   RfDataIn, 8'hA5);
        tick();
        check("t1_wr_norsp", RspValid, 2'b00);
        @(negedge Clk);
        idle_all();
        set_req(1, 1'b1, 1'b0, 2'd2, 8'h00, 1'b0);
        #1;
        check("t1_rd_ready", ReqReady, 2'b10);
        check("t1_rd_we",    RfWriteEn, 1'b0);
        tick();
        check("t1_rspv",     RspValid, 2'b10);
        check("t1_rdata1",   RspRdata[1], 8'hA5);
        @(negedge Clk);
        idle_all();
        #1;
        check("t1_idle_ready", ReqReady, 2'b00);
        tick();
        check("t1_pulse",    RspValid, 2'b00);
        check("t1_hold",     RspRdata[1], 8'hA5);

        // ---------------- test 2: alternating grants under contention ----------------
        // req0 writes addr1 and req1 reads addr1. Each read sees the preceding write.
        @(negedge Clk);
        set_req(0, 1'b1, 1'b1, 2'd1, 8'h11, 1'b0);
        set_req(1, 1'b1, 1'b0, 2'd1, 8'h00, 1'b0);
        #1;
        check("t2_g0_ready", ReqReady, 2'b01);
        check("t2_g0_we",    RfWriteEn, 1'b1);
        check("t2_g0_din",   RfDataIn, 8'h11);
        tick();
        @(negedge Clk);
        #1;
        check("t2_g1_ready", ReqReady, 2'b10);
        check("t2_g1_we",    RfWriteEn, 1'b0);
        check("t2_g1_addr",  RfAddrB, 2'd1);
        tick();
        check("t2_g1_rspv",  RspValid, 2'b10);
        check("t2_g1_rdata", RspRdata[1], 8'h11);
        @(negedge Clk);
        ReqWdata[0] = 8'h22;
        #1;
        check("t2_g2_ready", ReqReady, 2'b01);
        check("t2_g2_we",    RfWriteEn, 1'b1);
        tick();
        check("t2_g2_rspv",  RspValid, 2'b00);
        @(negedge Clk);
        #1;
        check("t2_g3_ready", ReqReady, 2'b10);
        tick();
        check("t2_g3_rdata", RspRdata[1], 8'h22);

        // Single req0 write moves the round-robin pointer to req1.
        @(negedge Clk);
        idle_all();
        set_req(0, 1'b1, 1'b1, 2'd0, 8'h5A, 1'b0);
        #1;
        check("t2_solo_ready", ReqReady, 2'b01);
        tick();

        // ---------------- test 3: req1 locked burst of three writes ----------------
        @(negedge Clk);
        set_req(0, 1'b1, 1'b1, 2'd0, 8'h0F, 1'b1);
        set_req(1, 1'b1, 1'b1, 2'd3, 8'h31, 1'b1);
        #1;
        check("t3_b1_ready", ReqReady, 2'b10);
        check("t3_b1_din",   RfDataIn, 8'h31);
        tick();
        @(negedge Clk);
        set_req(1, 1'b1, 1'b1, 2'd3, 8'h32, 1'b1);
        #1;
        check("t3_b2_ready", ReqReady, 2'b10);
        check("t3_b2_din",   RfDataIn, 8'h32);
        tick();
        @(negedge Clk);
        set_req(1, 1'b1, 1'b1, 2'd3, 8'h33, 1'b0);
        #1;
        check("t3_b3_ready", ReqReady, 2'b10);
        check("t3_b3_addr",  RfAddrB, 2'd3);
        tick();

        // ---------------- test 4: req0 locks and is force-released ----------------
        // Entry grant: req0 writes addr0 with lock set. req1 keeps requesting.
        @(negedge Clk);
        set_req(1, 1'b1, 1'b1, 2'd2, 8'h77, 1'b0);
        #1;
        check("t3_after_ready", ReqReady, 2'b01);
        check("t3_after_din",   RfDataIn, 8'h0F);
        tick();
        // HOLD cycle 1: read addr3.
        @(negedge Clk);
        set_req(0, 1'b1, 1'b0, 2'd3, 8'h00, 1'b1);
        #1;
        check("t4_h1_ready", ReqReady, 2'b01);
        tick();
        check("t4_h1_rspv",  RspValid, 2'b01);
        check("t4_h1_rdata", RspRdata[0], 8'h33);
        // HOLD cycle 2: owner drops valid, but the port stays locked.
        @(negedge Clk);
        ReqValid[0] = 1'b0;
        #1;
        check("t4_h2_ready", ReqReady, 2'b00);
        check("t4_h2_we",    RfWriteEn, 1'b0);
        tick();
        check("t4_h2_rspv",  RspValid, 2'b00);
        // HOLD cycle 3: read addr0.
        @(negedge Clk);
        set_req(0, 1'b1, 1'b0, 2'd0, 8'h00, 1'b1);
        #1;
        check("t4_h3_ready", ReqReady, 2'b01);
        tick();
        check("t4_h3_rdata", RspRdata[0], 8'h0F);
        // HOLD cycle 4: the last allowed cycle. Its transfer still completes.
        @(negedge Clk);
        set_req(0, 1'b1, 1'b0, 2'd3, 8'h00, 1'b1);
        #1;
        check("t4_h4_ready", ReqReady, 2'b01);
        tick();
        check("t4_h4_rspv",  RspValid, 2'b01);
        // Forced release: req1 wins even though req0 is still valid and locking.
        @(negedge Clk);
        #1;
        check("t4_rel_ready", ReqReady, 2'b10);
        check("t4_rel_we",    RfWriteEn, 1'b1);
        check("t4_rel_din",   RfDataIn, 8'h77);
        tick();
        check("t4_rel_rspv",  RspValid, 2'b00);

        // ---------------- test 5: reset in the middle of a locked burst ----------------
        @(negedge Clk);
        idle_all();
        set_req(0, 1'b1, 1'b1, 2'd1, 8'h44, 1'b0);
        #1;
        check("t5_pre_ready", ReqReady, 2'b01);
        tick();
        @(negedge Clk);
        set_req(0, 1'b1, 1'b0, 2'd1, 8'h00, 1'b0);
        set_req(1, 1'b1, 1'b0, 2'd2, 8'h00, 1'b1);
        #1;
        check("t5_lock_ready", ReqReady, 2'b10);
        tick();
        check("t5_lock_rdata", RspRdata[1], 8'h77);
        @(negedge Clk);
        set_req(1, 1'b1, 1'b0, 2'd1, 8'h00, 1'b1);
        #1;
        check("t5_hold_ready", ReqReady, 2'b10);
        #2;
        Reset = 1'b1;
        #1;
        check("t5_rst_ready", ReqReady, 2'b00);
        check("t5_rst_we",    RfWriteEn, 1'b0);
        check("t5_rst_addr",  RfAddrB, 2'd0);
        check("t5_rst_rspv",  RspValid, 2'b00);
        check("t5_rst_rdata", RspRdata[1], 8'h00);
        tick();
        check("t5_rst_rspv2", RspValid, 2'b00);
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        check("t5_post_ready", ReqReady, 2'b01);
        check("t5_post_addr",  RfAddrB, 2'd1);
        tick();
        check("t5_post_rspv",  RspValid, 2'b01);
        check("t5_post_rdata", RspRdata[0], 8'h44);

        // ---------------- test 6: idle port ----------------
        for (int c = 0; c < 10; c++) begin
            @(negedge Clk);
            idle_all();
            #1;
            check($sformatf("t6_ready_%0d", c), ReqReady, 2'b00);
            check($sformatf("t6_we_%0d", c),    RfWriteEn, 1'b0);
            check($sformatf("t6_addr_%0d", c),  RfAddrB, 2'd0);
            tick();
            check($sformatf("t6_rspv_%0d", c),  RspValid, 2'b00);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
